// File: rtl/tx_beamform_pkg.sv
// Shared types and sizing for the transmit beamformer: controller states,
// default channel count and the width used for per-channel delays.
package tx_beamform_pkg;

   typedef enum logic [1:0] {IDLE, FIRE, DONE} state_t;

   localparam int NUM_TX_DEFAULT = 4;

   // A delay of (NUM_TX-1)*255 must fit without truncation.
   localparam int DELAY_W = 8 + $clog2(NUM_TX_DEFAULT);

   function automatic int delayWidth(input int numTx);
      return 8 + $clog2(numTx);
   endfunction

endpackage

// File: rtl/tx_channel.sv
// One transducer channel: waits out its steering delay, then emits a burst of
// square-wave periods starting high, and holds its output low afterwards.
module tx_channel
   import tx_beamform_pkg::*;
#(
   parameter int DW           = DELAY_W,
   parameter int CLK_PER_HALF = 1250,
   parameter int BURST_CYCLES = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_clear,
   input  logic [DW-1:0] i_delay,
   output logic          o_tx,
   output logic          o_finished
);

   localparam int HW = $clog2(CLK_PER_HALF + 1);
   localparam int EW = $clog2(2 * BURST_CYCLES + 1);
   localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_PER_HALF - 1);
   localparam logic [EW-1:0] EDGE_RELOAD = EW'(2 * BURST_CYCLES - 1);

   logic [DW-1:0] r_delayCnt;
   logic [HW-1:0] r_halfCnt;
   logic [EW-1:0] r_edgeCnt;
   logic          r_waiting;
   logic          r_running;
   logic          r_finished;
   logic          r_tx;
   logic          w_lastCycle;

   // The final low half-period already counts as finished so the controller
   // can leave FIRE on the very edge that ends the burst.
   assign w_lastCycle = r_running && (r_halfCnt == '0) && (r_edgeCnt == '0);
   assign o_finished  = r_finished | w_lastCycle;
   assign o_tx        = r_tx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_delayCnt <= '0;
         r_halfCnt  <= '0;
         r_edgeCnt  <= '0;
         r_waiting  <= 1'b0;
         r_running  <= 1'b0;
         r_finished <= 1'b0;
         r_tx       <= 1'b0;
      end else if (i_clear) begin
         r_waiting  <= 1'b0;
         r_running  <= 1'b0;
         r_finished <= 1'b0;
         r_tx       <= 1'b0;
      end else if (i_load) begin
         r_delayCnt <= i_delay;
         r_waiting  <= 1'b1;
         r_running  <= 1'b0;
         r_finished <= 1'b0;
         r_tx       <= 1'b0;
      end else if (r_waiting) begin
         if (r_delayCnt == '0) begin
            r_waiting <= 1'b0;
            r_running <= 1'b1;
            r_tx      <= 1'b1;
            r_halfCnt <= HALF_RELOAD;
            r_edgeCnt <= EDGE_RELOAD;
         end else begin
            r_delayCnt <= r_delayCnt - DW'(1);
         end
      end else if (r_running) begin
         // r_edgeCnt counts the phase flips still owed in this burst.
         if (r_halfCnt == '0) begin
            if (r_edgeCnt == '0) begin
               r_running  <= 1'b0;
               r_finished <= 1'b1;
               r_tx       <= 1'b0;
            end else begin
               r_tx      <= ~r_tx;
               r_halfCnt <= HALF_RELOAD;
               r_edgeCnt <= r_edgeCnt - EW'(1);
            end
         end else begin
            r_halfCnt <= r_halfCnt - HW'(1);
         end
      end
   end

endmodule

// File: rtl/transmit_beamform.sv
// Steered multi-channel 40 kHz burst transmitter with a one-shot controller.
// Define TX_ABORT_EN to add an abort input that cancels a shot in progress.
module transmit_beamform
   import tx_beamform_pkg::*;
#(
   parameter int NUM_TX       = NUM_TX_DEFAULT,
   parameter int CLK_PER_HALF = 1250,
   parameter int BURST_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        delay_step,
   input  logic              steer_neg,
`ifdef TX_ABORT_EN
   input  logic              abort,
`endif
   output logic [NUM_TX-1:0] tx_out,
   output logic              busy,
   output logic              done
);

   localparam int DW = delayWidth(NUM_TX);

   state_t            r_state;
   state_t            w_nextState;
   logic              w_accept;
   logic              w_abort;
   logic              w_allFinished;
   logic [NUM_TX-1:0] w_finished;

   assign w_accept      = (r_state == IDLE) && start;
   assign w_allFinished = &w_finished;

`ifdef TX_ABORT_EN
   assign w_abort = (r_state == FIRE) && abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Abort outranks completion so a cancelled shot never reports done.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = FIRE;
         FIRE: begin
            if (w_abort) begin
               w_nextState = IDLE;
            end else if (w_allFinished) begin
               w_nextState = DONE;
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   assign busy = (r_state == FIRE);
   assign done = (r_state == DONE);

   // Each channel captures its delay on the accept edge, which is what
   // freezes delay_step and steer_neg for the rest of the shot.
   for (genvar i = 0; i < NUM_TX; i++) begin : g_ch
      localparam logic [DW-1:0] IDX_FWD = DW'(i);
      localparam logic [DW-1:0] IDX_REV = DW'(NUM_TX - 1 - i);
      logic [DW-1:0] w_delay;

      assign w_delay = (steer_neg ? IDX_REV : IDX_FWD) * DW'(delay_step);

      tx_channel #(
         .DW           (DW),
         .CLK_PER_HALF (CLK_PER_HALF),
         .BURST_CYCLES (BURST_CYCLES)
      ) u_channel (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_load     (w_accept),
         .i_clear    (w_abort),
         .i_delay    (w_delay),
         .o_tx       (tx_out[i]),
         .o_finished (w_finished[i])
      );
   end

endmodule

// File: tb/tb_transmit_beamform.sv
// Scoreboard bench for transmit_beamform with CLK_PER_HALF=2, BURST_CYCLES=2.
// The abort scenario is built only when TX_ABORT_EN is defined.
module tb_transmit_beamform;

   localparam int NUM_TX = 4;
   localparam int CPH    = 2;
   localparam int BC     = 2;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              start     = 1'b0;
   logic [7:0]        delayStep = 8'd0;
   logic              steerNeg  = 1'b0;
`ifdef TX_ABORT_EN
   logic              abort     = 1'b0;
`endif
   logic [NUM_TX-1:0] txOut;
   logic              busy;
   logic              done;

   transmit_beamform #(
      .NUM_TX       (NUM_TX),
      .CLK_PER_HALF (CPH),
      .BURST_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .delay_step (delayStep),
      .steer_neg  (steerNeg),
`ifdef TX_ABORT_EN
      .abort      (abort),
`endif
      .tx_out     (txOut),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far; expected samples are stamped with it.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                stamp;
      int                tag;
      int                t;
      logic [NUM_TX-1:0] tx;
      logic              busy;
      logic              done;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passes = 0;

   task automatic checkOutput(input exp_t e);
      checks++;
      if (txOut === e.tx && busy === e.busy && done === e.done) begin
         passes++;
      end else begin
         $display("[TB] FAIL shot%0d t=%0d: got tx=%b busy=%b done=%b, expected tx=%b busy=%b done=%b",
                  e.tag, e.t, txOut, busy, done, e.tx, e.busy, e.done);
      end
   endtask

   // Square wave starting high at t=1+d, CPH high / CPH low, BC periods.
   function automatic logic expBit(input int t, input int d);
      int rel;
      rel = t - 1 - d;
      if (rel < 0 || rel >= 2 * BC * CPH) return 1'b0;
      return ((rel / CPH) % 2) == 0;
   endfunction

   // doneT is the hand-derived done edge; samples from cutT on are all zero.
   task automatic pushShot(input int k, input int tag, input logic [7:0] ds, input logic neg,
                           input int doneT, input int cutT, input int lastT);
      exp_t e;
      for (int t = 1; t <= lastT; t++) begin
         e.stamp = k + t;
         e.tag   = tag;
         e.t     = t;
         for (int i = 0; i < NUM_TX; i++) begin
            e.tx[i] = (t < cutT) ? expBit(t, (neg ? (NUM_TX - 1 - i) : i) * int'(ds)) : 1'b0;
         end
         e.busy = (t < doneT) && (t < cutT);
         e.done = (t == doneT) && (t < cutT);
         sbq.push_back(e);
      end
   endtask

   // Called on a falling edge; start is accepted on the next rising edge k.
   // Inputs are scrambled right after acceptance to exercise latching.
   task automatic applyStimulus(input int tag, input logic [7:0] ds, input logic neg,
                                input int doneT, input int cutT, input int lastT);
      int k;
      k = cyc + 1;
      pushShot(k, tag, ds, neg, doneT, cutT, lastT);
      delayStep = ds;
      steerNeg  = neg;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      delayStep = ~ds;
      steerNeg  = ~neg;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].stamp <= cyc) begin
            e = sbq.pop_front();
            if (e.stamp < cyc) begin
               checks++;
               $display("[TB] FAIL shot%0d t=%0d: sample missed, at cycle %0d expected cycle %0d",
                        e.tag, e.t, cyc, e.stamp);
            end else begin
               checkOutput(e);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      exp_t z;
      z.stamp = 0;
      z.tx    = '0;
      z.busy  = 1'b0;
      z.done  = 1'b0;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      z.tag = 0;
      z.t   = 0;
      checkOutput(z);

      // Release and start together: the first edge after release accepts.
      rst_n = 1'b1;
      applyStimulus(1, 8'd3, 1'b0, 18, 99, 20);
      repeat (20) @(negedge clk);

      applyStimulus(2, 8'd3, 1'b1, 18, 99, 20);
      repeat (20) @(negedge clk);

      applyStimulus(3, 8'd0, 1'b0, 9, 99, 11);
      repeat (11) @(negedge clk);

      // A second start mid-shot must be ignored and must not queue a shot.
      applyStimulus(4, 8'd3, 1'b0, 18, 99, 22);
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (17) @(negedge clk);

      // Asynchronous reset just before edge 7 of a shot.
      applyStimulus(5, 8'd3, 1'b0, 18, 7, 8);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      z.tag = 5;
      z.t   = 6;
      checkOutput(z);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(6, 8'd3, 1'b0, 18, 99, 20);
      repeat (20) @(negedge clk);

`ifdef TX_ABORT_EN
      applyStimulus(7, 8'd3, 1'b0, 18, 7, 20);
      repeat (6) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (13) @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      if (sbq.size() != 0) begin
         checks++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
